// File: rtl/periph_pkg.sv
// periph_pkg: shared constants for the memory-mapped peripheral block.
//   PERIPH_BASE_ADDR : default base of the 32-byte peripheral window
//   OFF_*            : word-aligned byte offsets of each register in the window
//   TCON_*           : bit indices inside the timer control register
package periph_pkg;

    localparam logic [31:0] PERIPH_BASE_ADDR = 32'h4000_0000;

    localparam logic [4:0] OFF_TH      = 5'h00;
    localparam logic [4:0] OFF_TL      = 5'h04;
    localparam logic [4:0] OFF_TCON    = 5'h08;
    localparam logic [4:0] OFF_LED     = 5'h0C;
    localparam logic [4:0] OFF_SWITCH  = 5'h10;
    localparam logic [4:0] OFF_DIGI    = 5'h14;
    localparam logic [4:0] OFF_SYSTICK = 5'h18;

    localparam int TCON_EN = 0;   // count enable
    localparam int TCON_IE = 1;   // interrupt enable
    localparam int TCON_IS = 2;   // interrupt status (sticky)

endpackage

// File: rtl/periph_timer.sv
// periph_timer: reloadable 32-bit up-counter with interrupt.
//   clk, reset     : clock, asynchronous active-low reset
//   iThWrite       : load TH from iWriteData this edge
//   iTlWrite       : load TL from iWriteData this edge (beats count/reload)
//   iTconWrite     : load TCON[1:0]; TCON[2] cleared if iWriteData[2]==0
//   iWriteData     : CPU write data
//   oTh, oTl, oTcon: register contents for the read mux
//   oIrq           : level interrupt, TCON[IE] & TCON[IS]
module periph_timer
    import periph_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        iThWrite,
    input  logic        iTlWrite,
    input  logic        iTconWrite,
    input  logic [31:0] iWriteData,
    output logic [31:0] oTh,
    output logic [31:0] oTl,
    output logic [2:0]  oTcon,
    output logic        oIrq
);

    logic [31:0] thReg;
    logic [31:0] tlReg;
    logic [31:0] tlNext;
    logic [2:0]  tconReg;
    logic [2:0]  tconNext;
    logic        overflow;

    assign overflow = tconReg[TCON_EN] && (tlReg == 32'hFFFF_FFFF);

    always_comb begin
        tlNext   = tlReg;
        tconNext = tconReg;

        // A CPU write to TL wins over both increment and reload. Reload uses
        // the TH value from before this edge even if TH is written now.
        if (iTlWrite) begin
            tlNext = iWriteData;
        end else if (overflow) begin
            tlNext = thReg;
        end else if (tconReg[TCON_EN]) begin
            tlNext = tlReg + 32'd1;
        end

        if (iTconWrite) begin
            tconNext[TCON_EN] = iWriteData[TCON_EN];
            tconNext[TCON_IE] = iWriteData[TCON_IE];
            if (!iWriteData[TCON_IS]) begin
                tconNext[TCON_IS] = 1'b0;
            end
        end

        // Setting the status has priority over a simultaneous software clear
        // so an overflow is never lost. An overflow overridden by a TL write
        // does not count. IE is taken from before this edge.
        if (overflow && tconReg[TCON_IE] && !iTlWrite) begin
            tconNext[TCON_IS] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            thReg   <= '0;
            tlReg   <= '0;
            tconReg <= '0;
        end else begin
            if (iThWrite) begin
                thReg <= iWriteData;
            end
            tlReg   <= tlNext;
            tconReg <= tconNext;
        end
    end

    assign oTh   = thReg;
    assign oTl   = tlReg;
    assign oTcon = tconReg;
    assign oIrq  = tconReg[TCON_IE] & tconReg[TCON_IS];

endmodule

// File: rtl/periph_bus.sv
// periph_bus: memory-mapped peripheral slave on the core data bus.
//   clk, reset     : clock, asynchronous active-low reset
//   iMemAddr       : byte address; window is addr[31:5] == BASE_ADDR[31:5]
//   iMemRead/Write : bus strobes
//   iMemWriteData  : write data
//   oMemReadData   : combinational read data (0 unless read strobe and hit)
//   oHit           : address inside the window, independent of strobes
//   iSwitch        : asynchronous board switches (2-flop synchronised)
//   oLed, oDigi    : LED and 7-seg registers
//   oIrq           : timer interrupt level
module periph_bus
    import periph_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR  = PERIPH_BASE_ADDR,
    parameter int          SW_WIDTH   = 8,
    parameter int          LED_WIDTH  = 8,
    parameter int          DIGI_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [31:0]           iMemAddr,
    input  logic                  iMemRead,
    input  logic                  iMemWrite,
    input  logic [31:0]           iMemWriteData,
    output logic [31:0]           oMemReadData,
    output logic                  oHit,
    input  logic [SW_WIDTH-1:0]   iSwitch,
    output logic [LED_WIDTH-1:0]  oLed,
    output logic [DIGI_WIDTH-1:0] oDigi,
    output logic                  oIrq
);

    logic [4:0]            wordOff;
    logic                  wrEn;
    logic [31:0]           th;
    logic [31:0]           tl;
    logic [2:0]            tcon;
    logic [LED_WIDTH-1:0]  ledReg;
    logic [DIGI_WIDTH-1:0] digiReg;
    logic [31:0]           sysTickReg;
    logic [SW_WIDTH-1:0]   swSync1Reg;
    logic [SW_WIDTH-1:0]   swSync2Reg;

    // Byte lane bits are ignored: mask them off rather than slicing them out.
    assign wordOff = iMemAddr[4:0] & 5'b11100;
    assign oHit    = (iMemAddr[31:5] == BASE_ADDR[31:5]);
    assign wrEn    = iMemWrite & oHit;

    periph_timer uTimer (
        .clk        (clk),
        .reset      (reset),
        .iThWrite   (wrEn && (wordOff == OFF_TH)),
        .iTlWrite   (wrEn && (wordOff == OFF_TL)),
        .iTconWrite (wrEn && (wordOff == OFF_TCON)),
        .iWriteData (iMemWriteData),
        .oTh        (th),
        .oTl        (tl),
        .oTcon      (tcon),
        .oIrq       (oIrq)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ledReg     <= '0;
            digiReg    <= '0;
            sysTickReg <= '0;
            swSync1Reg <= '0;
            swSync2Reg <= '0;
        end else begin
            if (wrEn && (wordOff == OFF_LED)) begin
                ledReg <= iMemWriteData[LED_WIDTH-1:0];
            end
            if (wrEn && (wordOff == OFF_DIGI)) begin
                digiReg <= iMemWriteData[DIGI_WIDTH-1:0];
            end
            sysTickReg <= sysTickReg + 32'd1;
            swSync1Reg <= iSwitch;
            swSync2Reg <= swSync1Reg;
        end
    end

    always_comb begin
        oMemReadData = '0;
        if (iMemRead && oHit) begin
            case (wordOff)
                OFF_TH:      oMemReadData = th;
                OFF_TL:      oMemReadData = tl;
                OFF_TCON:    oMemReadData = 32'(tcon);
                OFF_LED:     oMemReadData = 32'(ledReg);
                OFF_SWITCH:  oMemReadData = 32'(swSync2Reg);
                OFF_DIGI:    oMemReadData = 32'(digiReg);
                OFF_SYSTICK: oMemReadData = sysTickReg;
                default:     oMemReadData = '0;
            endcase
        end
    end

    assign oLed  = ledReg;
    assign oDigi = digiReg;

endmodule
